// File: rtl/aes_pkg.sv
// Shared definitions for the AES block stream adapter.
// Provides the block and word widths, the 128-bit block and 32-bit word
// types, the core-handshake FSM state encoding and a helper that picks one
// 32-bit word out of a block in FIPS-197 big-endian order.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } core_state_t;

  // Word 0 is the most significant word of the block.
  function automatic aes_word_t block_word(input aes_block_t blk, input logic [1:0] idx);
    aes_word_t word;
    case (idx)
      2'd0:    word = blk[127:96];
      2'd1:    word = blk[95:64];
      2'd2:    word = blk[63:32];
      default: word = blk[31:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/aes_word_pack.sv
// Input packer: gathers four 32-bit words from a valid/ready stream into one
// 128-bit block. The first word lands in bits [127:96], the fourth in [31:0].
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   s_data/s_valid upstream word and its valid
//   s_ready        high while no complete block is waiting to be loaded
//   consume        the core side has taken the complete block this cycle
//   block          the packed block (stable while full is high)
//   full           a complete block is waiting
//   partial        some, but not all, words of the next block have arrived
module aes_word_pack
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  aes_word_t  s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       consume,
  output aes_block_t block,
  output logic       full,
  output logic       partial
);

  logic [1:0] wcnt;
  logic       in_full;
  aes_block_t in_buf;
  logic       take;

  assign s_ready = !in_full;
  assign take    = s_valid && s_ready;
  assign block   = in_buf;
  assign full    = in_full;
  assign partial = (wcnt != 2'd0);

  // A completing fill takes priority over the consume clear: the consumer
  // already took the previous contents on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 2'd0;
      in_full <= 1'b0;
      in_buf  <= '0;
    end else begin
      if (take) begin
        case (wcnt)
          2'd0:    in_buf[127:96] <= s_data;
          2'd1:    in_buf[95:64]  <= s_data;
          2'd2:    in_buf[63:32]  <= s_data;
          default: in_buf[31:0]   <= s_data;
        endcase
        wcnt <= wcnt + 2'd1;
      end
      if (take && (wcnt == 2'd3)) begin
        in_full <= 1'b1;
      end else if (consume) begin
        in_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_block_stream.sv
// Word-stream adapter around an AES cipher core. Packs four plaintext words
// into a block, hands it to the core with a one-cycle load pulse, captures
// the core result and streams it back out as four ciphertext words.
// Filling, encryption and draining overlap, so up to three blocks are held.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_data/s_valid/s_ready  plaintext word stream in
//   m_data/m_valid/m_ready  ciphertext word stream out
//   aes_load/aes_pt         load pulse and block to the cipher core
//   aes_ct/aes_valid        result and single-cycle valid from the core
//   busy                    any block held anywhere in the adapter
//   err_timeout             sticky: core did not answer within TIMEOUT cycles
module aes_block_stream
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         aes_load,
  output logic [127:0] aes_pt,
  input  logic [127:0] aes_ct,
  input  logic         aes_valid,
  output logic         busy,
  output logic         err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  core_state_t state, state_next;
  logic [TW-1:0] tcnt;
  logic          load_go;
  logic          capture;
  logic          time_out;

  aes_block_t in_block;
  logic       in_full;
  logic       in_partial;

  aes_block_t out_buf;
  logic       out_full;
  logic [1:0] rcnt;

  aes_word_pack u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .consume (load_go),
    .block   (in_block),
    .full    (in_full),
    .partial (in_partial)
  );

  // Loads are held off while the output buffer is occupied, so a capture
  // can never overwrite ciphertext that has not been drained yet.
  // tcnt counts WAIT cycles since the load pulse; the core gets TIMEOUT of
  // them, and a result arriving on the final cycle still wins.
  always_comb begin
    state_next = state;
    load_go    = 1'b0;
    capture    = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: begin
        if (in_full && !out_full) begin
          load_go    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (aes_valid) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          time_out   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      aes_load    <= 1'b0;
      aes_pt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      aes_load <= load_go;
      if (load_go) begin
        aes_pt <= in_block;
        tcnt   <= '0;
      end else if (state == WAIT) begin
        tcnt <= tcnt + TW'(1);
      end
      if (time_out) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Capture only happens with the buffer empty, so rcnt is always 0 then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_buf  <= '0;
      out_full <= 1'b0;
      rcnt     <= 2'd0;
    end else if (capture) begin
      out_buf  <= aes_ct;
      out_full <= 1'b1;
    end else if (out_full && m_ready) begin
      rcnt <= rcnt + 2'd1;
      if (rcnt == 2'd3) begin
        out_full <= 1'b0;
      end
    end
  end

  assign m_valid = out_full;
  assign m_data  = block_word(out_buf, rcnt);
  assign busy    = in_full | in_partial | (state == WAIT) | out_full;

endmodule

// File: tb/tb_aes_block_stream.sv
// Self-checking bench for aes_block_stream. A behavioural core stand-in
// answers the FIPS-197 C.1 plaintext with the C.1 ciphertext (any other
// block with its bitwise inverse) after a fixed latency, or never answers
// when coreDead is set.
module tb_aes_block_stream;

  localparam int CORE_LAT = 10;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BP_PT = 128'h0123456789abcdeffedcba9876543210;

  logic         clk;
  logic         rst_n;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         aes_load;
  logic [127:0] aes_pt;
  logic [127:0] aes_ct;
  logic         aes_valid;
  logic         busy;
  logic         err_timeout;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0]  inWords[$];
  logic [31:0]  outQ[$];
  int           loadCount    = 0;
  int           mValidCycles = 0;
  int           outBase, loadBase, mvBase;
  bit           coreDead;
  logic [127:0] corePt;
  int           coreCnt;

  aes_block_stream #(.TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .aes_load    (aes_load),
    .aes_pt      (aes_pt),
    .aes_ct      (aes_ct),
    .aes_valid   (aes_valid),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: sees the load pulse mid-cycle and answers CORE_LAT
  // cycles later with a single-cycle valid.
  initial begin
    aes_valid = 1'b0;
    aes_ct    = '0;
    coreCnt   = 0;
    corePt    = '0;
  end
  always @(negedge clk) begin
    aes_valid = 1'b0;
    if (!rst_n) begin
      coreCnt = 0;
    end else if (aes_load) begin
      corePt  = aes_pt;
      coreCnt = coreDead ? 0 : CORE_LAT;
    end else if (coreCnt > 0) begin
      coreCnt--;
      if (coreCnt == 0) begin
        aes_valid = 1'b1;
        aes_ct    = (corePt == C1_PT) ? C1_CT : ~corePt;
      end
    end
  end

  // Records every accepted output word, load pulse and m_valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aes_load) loadCount++;
      if (m_valid) mValidCycles++;
      if (m_valid && m_ready) outQ.push_back(m_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic addBlock(input logic [127:0] pt);
    for (int i = 0; i < 4; i++) inWords.push_back(pt[127-32*i -: 32]);
  endtask

  task automatic markBases();
    outBase  = outQ.size();
    loadBase = loadCount;
    mvBase   = mValidCycles;
  endtask

  // Streams inWords; stallMode offers a word only every third cycle.
  task automatic applyStimulus(input bit stallMode, input int maxCycles);
    int idx = 0;
    int cyc = 0;
    bit fire;
    while (idx < inWords.size() && cyc < maxCycles) begin
      s_valid = stallMode ? ((cyc % 3) == 0) : 1'b1;
      s_data  = inWords[idx];
      fire    = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (fire) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    if (idx < inWords.size())
      checkOutput("stim_accept", 128'(idx), 128'(inWords.size()));
    inWords.delete();
  endtask

  task automatic waitOutputs(input string tag, input int n, input int budget);
    int c = 0;
    while ((outQ.size() - outBase) < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput({tag, "_count"}, 128'(outQ.size() - outBase), 128'(n));
  endtask

  task automatic checkWords(input string tag, input logic [127:0] ct, input int base);
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      got = ((base + i) < outQ.size()) ? outQ[base + i] : 32'hxxxxxxxx;
      checkOutput($sformatf("%s_w%0d", tag, i), 128'(got), 128'(ct[127-32*i -: 32]));
    end
  endtask

  int n;
  int badHold;

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    coreDead = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", 128'(s_ready), 128'd1);
    checkOutput("rst_m_valid", 128'(m_valid), 128'd0);
    checkOutput("rst_m_data", 128'(m_data), 128'd0);
    checkOutput("rst_aes_load", 128'(aes_load), 128'd0);
    checkOutput("rst_aes_pt", aes_pt, 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_err", 128'(err_timeout), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single C.1 block, load latency and drain
    $display("[TB] single C.1 block");
    markBases();
    addBlock(C1_PT);
    applyStimulus(1'b0, 50);
    checkOutput("c1_load_early", 128'(aes_load), 128'd0);
    @(posedge clk);
    #1;
    checkOutput("c1_load_pulse", 128'(aes_load), 128'd1);
    checkOutput("c1_aes_pt", aes_pt, C1_PT);
    waitOutputs("c1", 4, 100);
    checkWords("c1", C1_CT, outBase);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("c1_mvalid_cycles", 128'(mValidCycles - mvBase), 128'd4);
    checkOutput("c1_busy_after", 128'(busy), 128'd0);
    checkOutput("c1_loads", 128'(loadCount - loadBase), 128'd1);

    // Three blocks back to back
    $display("[TB] back-to-back");
    markBases();
    for (int b = 0; b < 3; b++) addBlock(C1_PT);
    applyStimulus(1'b0, 200);
    waitOutputs("b2b", 12, 200);
    for (int b = 0; b < 3; b++) checkWords($sformatf("b2b%0d", b), C1_CT, outBase + 4*b);
    checkOutput("b2b_loads", 128'(loadCount - loadBase), 128'd3);

    // Output back-pressure
    $display("[TB] back-pressure");
    m_ready = 1'b0;
    markBases();
    addBlock(C1_PT);
    applyStimulus(1'b0, 50);
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_first_valid", 128'(m_valid), 128'd1);
    addBlock(BP_PT);
    applyStimulus(1'b0, 50);
    badHold = 0;
    for (int c = 0; c < 50; c++) begin
      if (m_data !== C1_CT[127:96] || m_valid !== 1'b1) badHold++;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_hold_bad_cycles", 128'(badHold), 128'd0);
    checkOutput("bp_s_ready", 128'(s_ready), 128'd0);
    checkOutput("bp_loads_held", 128'(loadCount - loadBase), 128'd1);
    m_ready = 1'b1;
    waitOutputs("bp", 8, 200);
    checkWords("bp_blk0", C1_CT, outBase);
    checkWords("bp_blk1", ~BP_PT, outBase + 4);
    checkOutput("bp_loads", 128'(loadCount - loadBase), 128'd2);

    // Input stalls across word boundaries
    $display("[TB] input stalls");
    markBases();
    addBlock(C1_PT);
    addBlock(C1_PT);
    applyStimulus(1'b1, 200);
    waitOutputs("stall", 8, 200);
    checkWords("stall0", C1_CT, outBase);
    checkWords("stall1", C1_CT, outBase + 4);
    checkOutput("stall_loads", 128'(loadCount - loadBase), 128'd2);

    // Watchdog with a core that never answers
    $display("[TB] timeout");
    coreDead = 1'b1;
    markBases();
    addBlock(C1_PT);
    applyStimulus(1'b0, 50);
    @(posedge clk);
    #1;
    checkOutput("to_load", 128'(aes_load), 128'd1);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("to_cycles", 128'(n), 128'd64);
    checkOutput("to_busy", 128'(busy), 128'd0);
    checkOutput("to_no_mvalid", 128'(mValidCycles - mvBase), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("to_sticky", 128'(err_timeout), 128'd1);
    coreDead = 1'b0;

    // Reset after two words
    $display("[TB] reset mid-block");
    inWords.push_back(C1_PT[127:96]);
    inWords.push_back(C1_PT[95:64]);
    applyStimulus(1'b0, 20);
    checkOutput("rp_busy_before", 128'(busy), 128'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rp_busy", 128'(busy), 128'd0);
    checkOutput("rp_s_ready", 128'(s_ready), 128'd1);
    checkOutput("rp_err_cleared", 128'(err_timeout), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while waiting on the core
    addBlock(C1_PT);
    applyStimulus(1'b0, 50);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rw_busy_before", 128'(busy), 128'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rw_aes_pt", aes_pt, 128'd0);
    checkOutput("rw_aes_load", 128'(aes_load), 128'd0);
    checkOutput("rw_busy", 128'(busy), 128'd0);
    checkOutput("rw_m_valid", 128'(m_valid), 128'd0);
    checkOutput("rw_s_ready", 128'(s_ready), 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh block after reset
    markBases();
    addBlock(C1_PT);
    applyStimulus(1'b0, 50);
    waitOutputs("post", 4, 100);
    checkWords("post", C1_CT, outBase);
    checkOutput("post_loads", 128'(loadCount - loadBase), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_block_stream.md
Name: aes_block_stream

Overview:
Word-stream adapter that sits around the AES cipher core, both upstream and downstream of it.
- Upstream side: accepts 32-bit plaintext words on a valid/ready stream and packs four words into one 128-bit block.
- Core side: drives the core's load/pt inputs, then captures ct when the core's valid fires.
- Downstream side: returns the ciphertext as four 32-bit words on a valid/ready stream.
- Input filling, encryption and output draining overlap, so up to three blocks are in flight.

Parameters:
TIMEOUT, 64, max cycles allowed between aes_load and aes_valid before an error is flagged (must be >= Nr+2 of the core).
TW, $clog2(TIMEOUT+1), width of the watchdog counter (derived, not overridden).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_data  in  32  plaintext word
s_valid  in  1  s_data valid
s_ready  out  1  block accepts s_data this cycle
m_data  out  32  ciphertext word
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data
aes_load  out  1  one-cycle load pulse to cipher core
aes_pt  out  128  block presented to cipher core
aes_ct  in  128  cipher core result
aes_valid  in  1  cipher core result valid (single-cycle pulse)
busy  out  1  any block held in input buffer, core or output buffer
err_timeout  out  1  sticky: core failed to answer within TIMEOUT cycles

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: s_ready=1, m_valid=0, m_data=0, aes_load=0, aes_pt=0, busy=0, err_timeout=0. All counters and buffers cleared.
- Reset mid-operation discards all partial and complete blocks; the core is not notified.
- Byte order follows FIPS-197 big-endian: the first word of a block maps to bits [127:96], the fourth to [31:0]. Output uses the same order.
- Input side:
  - 2-bit word counter wcnt plus an in_full flag.
  - A transfer occurs when s_valid && s_ready. The word is written to in_buf slot wcnt, and wcnt increments.
  - On the 4th word, wcnt wraps to 0 and in_full is set.
  - s_ready = !in_full.
- Core FSM with states IDLE, WAIT:
  - IDLE -> WAIT when in_full && !out_full. In that cycle, register aes_pt <= in_buf, pulse aes_load=1 on the next cycle, and clear in_full. The input side may start the next block the cycle after.
  - aes_pt holds its value until the next load.
  - WAIT, on aes_valid: capture aes_ct into out_buf, set out_full, return to IDLE.
  - aes_valid outside WAIT is ignored.
  - The out_full precondition guarantees capture never overwrites undrained data.
  - WAIT watchdog: tcnt counts from 0 starting the cycle after aes_load. If tcnt reaches TIMEOUT without aes_valid: set err_timeout, return to IDLE, drop the block. err_timeout clears only on reset.
  - Minimum latency: last input word accepted -> aes_load is 2 cycles; aes_valid -> m_valid is 1 cycle.
- Output side:
  - 2-bit counter rcnt.
  - m_valid = out_full; m_data = out_buf word rcnt.
  - On m_valid && m_ready, rcnt increments. On the 4th word, rcnt wraps to 0 and out_full clears.
  - m_data and m_valid hold stable while m_ready is low.
- Simultaneous events:
  - The input fill completing in the same cycle as an IDLE->WAIT load: in_full is cleared by the load and set by the fill. The fill wins, because the load consumed the previous content on that cycle's edge.
  - The last output word draining in the same cycle aes_valid arrives cannot happen, since loads are gated by !out_full.
- busy = in_full | (wcnt != 0) | (state == WAIT) | out_full.
- Throughput: one block per max(4 input cycles, core latency + 2, 4 output cycles).

Decomposition:
- Shared package aes_pkg: AES_BLOCK_W=128, AES_WORD_W=32, a typedef for a 128-bit block, and an enum typedef for core FSM states {IDLE, WAIT}.
- One natural sub-module: aes_word_pack, the 4x32 -> 128 input packer with its counter and in_full flag. The output unpacker stays inline.

Test Plan:
- FIPS-197 C.1 vector, with a real cipher core attached (key 000102030405060708090a0b0c0d0e0f):
  - stimulus: words 00112233, 44556677, 8899aabb, ccddeeff, with m_ready=1;
  - required response: m_data sequence 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, m_valid exactly 4 cycles, busy falls after the last word.
- Back-to-back: 3 copies of the C.1 block streamed with s_valid always high -> 12 output words, the C.1 ciphertext 3 times. s_ready drops only while in_full and the core/output are occupied.
- Output back-pressure: hold m_ready=0 for 50 cycles after the first ciphertext:
  - m_data stays 69c4e0d8 throughout;
  - a second block is fully accepted, then s_ready=0;
  - no aes_load issues while out_full.
- Input stalls: s_valid toggled 1,0,0,1,... across the word boundaries -> identical ciphertext; aes_load fires exactly once per 4 accepted words.
- Timeout: stub core that never asserts aes_valid, TIMEOUT=64 -> err_timeout rises exactly 64 cycles after aes_load; FSM returns to IDLE; no m_valid.
- Reset mid-block: assert rst_n=0 after 2 words and during WAIT -> all outputs return to reset values asynchronously. A fresh C.1 block afterwards yields the correct ciphertext.
